beatmap_sequencer: RTL and testbench

- Consumer stage directly downstream of the beatmap note ROM: drives its address, takes its 4-bit lane masks (1-cycle registered read latency) and schedules them into falling-note lane columns.
- Once per beat, every column shifts down one row and the current ROM word is inserted at the top row.
- Outputs the full playfield grid and the bottom row, which is the judgement row, for the renderer and the hit/score logic.
- Top-level FSM controls start, pause, end-of-map drain and done.

---
 rtl/beatmap_pkg.sv | 31 +++
 rtl/lane_shifter.sv | 51 +++++
 rtl/beatmap_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_beatmap_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beatmap_pkg.sv
// ----------------------------------------------------------------------------
// beatmap_pkg
// Shared definitions for the beatmap sequencer:
//   - state_e   : top-level sequencer states
//   - DEF_*     : default build constants for the top-level parameters
//   - grid_idx  : flat bit index of (row, lane) inside the packed playfield
// ----------------------------------------------------------------------------
package beatmap_pkg;

    localparam int DEF_LANES     = 4;
    localparam int DEF_ROWS      = 16;
    localparam int DEF_NUM_NOTES = 80;
    localparam int DEF_ADDR_W    = 13;
    localparam int DEF_TICK_DIV  = 12500000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // Row 0 is the top of the playfield; lanes are packed inside each row.
    function automatic int unsigned grid_idx(input int unsigned row,
                                             input int unsigned lane,
                                             input int unsigned lanes);
        return row * lanes + lane;
    endfunction

endpackage

// File: rtl/lane_shifter.sv
// ----------------------------------------------------------------------------
// lane_shifter
// One falling-note column. On shift_i every bit moves one row down (towards
// the judgement row at index ROWS-1) and sin_i enters at row 0.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (column cleared)
//   clear_i     : synchronous clear, has priority over shift_i
//   shift_i     : shift the column down by one row
//   sin_i       : bit inserted at row 0 on a shift
//   col_o       : column contents, bit r = row r
// ----------------------------------------------------------------------------
module lane_shifter
    import beatmap_pkg::*;
#(
    parameter int ROWS = DEF_ROWS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_i,
    input  logic            shift_i,
    input  logic            sin_i,
    output logic [ROWS-1:0] col_o
);

    logic [ROWS-1:0] col_q;
    logic [ROWS-1:0] col_d;

    // NOTE: assign every always_comb output a default first, otherwise any
    // path that skips an assignment infers a latch.
    always_comb begin
        col_d = col_q;
        if (clear_i) begin
            col_d = '0;
        end else if (shift_i) begin
            col_d = {col_q[ROWS-2:0], sin_i};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q <= '0;
        end else begin
            col_q <= col_d;
        end
    end

    assign col_o = col_q;

endmodule

// File: rtl/beatmap_sequencer.sv
// ----------------------------------------------------------------------------
// beatmap_sequencer
// Walks the beatmap note ROM and schedules its lane masks into falling-note
// columns. Once per beat (TICK_DIV clocks) the playfield shifts down one row
// and the current ROM word enters row 0. After the last note the field is
// drained with empty rows before DONE.
//
// Optional feature, macro BEATMAP_LOOP_EN: when defined the map loops
// forever (address and note_idx wrap after entry NUM_NOTES-1, no drain/done).
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : 1-cycle pulse, begin/restart the map (ignored while busy)
//   pause      : level, freezes beat timing in RUN and DRAIN
//   rom_addr   : note ROM address
//   rom_data   : registered ROM word, valid 1 cycle after rom_addr
//   grid       : playfield, bit [r*LANES+l] = lane l, row r (row 0 on top)
//   hit_row    : judgement row, grid row ROWS-1
//   beat       : 1-cycle pulse in the cycle whose clock edge shifts the grid
//   note_idx   : notes inserted so far
//   busy       : high in LOAD, RUN, DRAIN
//   done       : high in DONE
// ----------------------------------------------------------------------------
module beatmap_sequencer
    import beatmap_pkg::*;
#(
    parameter int NUM_NOTES = DEF_NUM_NOTES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int LANES     = DEF_LANES,
    parameter int ROWS      = DEF_ROWS,
    parameter int TICK_DIV  = DEF_TICK_DIV
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pause,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [LANES-1:0]      rom_data,
    output logic [LANES*ROWS-1:0] grid,
    output logic [LANES-1:0]      hit_row,
    output logic                  beat,
    output logic [ADDR_W-1:0]     note_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int DIV_W   = $clog2(TICK_DIV);
    localparam int DRAIN_W = $clog2(ROWS + 1);

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0]  NOTE_LAST  = ADDR_W'(NUM_NOTES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ROWS - 1);

    state_e               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [ADDR_W-1:0]    note_q, note_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 tick;
    logic                 grid_clr;
    logic [LANES-1:0]     ins_data;
    logic [LANES-1:0][ROWS-1:0] col;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            note_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            note_q  <= note_d;
            drain_q <= drain_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and beat timing
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        note_d   = note_q;
        drain_d  = drain_q;
        tick     = 1'b0;
        grid_clr = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                // Counters and grid are cleared on the accepting edge so the
                // LOAD cycle already presents a clean map at address 0.
                if (start) begin
                    state_d  = LOAD;
                    div_d    = '0;
                    note_d   = '0;
                    drain_d  = '0;
                    grid_clr = 1'b1;
                end
            end

            LOAD: begin
                // Single cycle that lets the ROM return entry 0.
                state_d  = RUN;
                div_d    = '0;
                note_d   = '0;
                drain_d  = '0;
                grid_clr = 1'b1;
            end

            RUN: begin
                // Pause simply withholds the increment, so a terminal count
                // seen during pause is replayed on the first unpaused cycle.
                if (!pause) begin
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        tick  = 1'b1;
`ifdef BEATMAP_LOOP_EN
                        if (note_q == NOTE_LAST) begin
                            note_d = '0;
                        end else begin
                            note_d = note_q + 1'b1;
                        end
`else
                        note_d = note_q + 1'b1;
                        if (note_q == NOTE_LAST) begin
                            state_d = DRAIN;
                        end
`endif
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end

            DRAIN: begin
                if (!pause) begin
                    if (div_q == DIV_LAST) begin
                        div_d   = '0;
                        tick    = 1'b1;
                        drain_d = drain_q + 1'b1;
                        if (drain_q == DRAIN_LAST) begin
                            state_d = DONE;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Playfield columns
    // ------------------------------------------------------------------
    // ROM words only enter during RUN; DRAIN pushes empty rows.
    assign ins_data = (state_q == RUN) ? rom_data : '0;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        lane_shifter #(
            .ROWS(ROWS)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .clear_i (grid_clr),
            .shift_i (tick),
            .sin_i   (ins_data[l]),
            .col_o   (col[l])
        );
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar l = 0; l < LANES; l++) begin : g_bit
            assign grid[grid_idx(r, l, LANES)] = col[l][r];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // During DRAIN note_idx sits at NUM_NOTES, but the address stays on the
    // last valid entry.
    always_comb begin
        rom_addr = '0;
        case (state_q)
            LOAD, RUN: rom_addr = note_q;
            DRAIN:     rom_addr = NOTE_LAST;
            default:   rom_addr = '0;
        endcase
    end

    assign hit_row  = grid[(ROWS-1)*LANES +: LANES];
    assign beat     = tick;
    assign note_idx = note_q;
    assign busy     = (state_q == LOAD) || (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_beatmap_sequencer.sv
// ----------------------------------------------------------------------------
// tb_beatmap_sequencer
// Small map (TICK_DIV=4, ROWS=4, NUM_NOTES=6) with a 1-cycle stub ROM.
// A behavioural model (beat phase counter, row array, note count) predicts
// every output each cycle; directed sections pin the model to hand-computed
// values, then randomized pause/start/reset traffic runs against it.
// Define BEATMAP_LOOP_EN for both DUT and bench to exercise looping.
// ----------------------------------------------------------------------------
module tb_beatmap_sequencer;

    localparam int TD = 4;
    localparam int RW = 4;
    localparam int NN = 6;
    localparam int LN = 4;
    localparam int AW = 13;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              pause = 1'b0;
    logic [AW-1:0]     rom_addr;
    logic [LN-1:0]     rom_data = '0;
    logic [LN*RW-1:0]  grid;
    logic [LN-1:0]     hit_row;
    logic              beat;
    logic [AW-1:0]     note_idx;
    logic              busy;
    logic              done;

    logic [LN-1:0] rom_tbl [NN] = '{4'b1000, 4'b0100, 4'b0010,
                                   4'b0001, 4'b1100, 4'b0101};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    beatmap_sequencer #(
        .NUM_NOTES (NN),
        .ADDR_W    (AW),
        .LANES     (LN),
        .ROWS      (RW),
        .TICK_DIV  (TD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pause    (pause),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .grid     (grid),
        .hit_row  (hit_row),
        .beat     (beat),
        .note_idx (note_idx),
        .busy     (busy),
        .done     (done)
    );

    // Stub ROM, one cycle of read latency.
    always @(posedge clk) begin
        if (rom_addr < AW'(NN)) rom_data <= rom_tbl[rom_addr[2:0]];
        else                    rom_data <= '0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef enum {M_IDLE, M_LOAD, M_RUN, M_DRAIN, M_DONE} mmode_e;

    mmode_e        m_mode    = M_IDLE;
    int            m_phase   = 0;   // unpaused active cycles since last beat
    int            m_notes   = 0;
    int            m_drained = 0;
    logic [LN-1:0] m_rows [RW] = '{default: '0};

    function automatic bit m_tick();
        return (m_mode == M_RUN || m_mode == M_DRAIN) && !pause && (m_phase == TD - 1);
    endfunction

    function automatic logic [LN*RW-1:0] m_grid();
        logic [LN*RW-1:0] g;
        for (int r = 0; r < RW; r++) g[r*LN +: LN] = m_rows[r];
        return g;
    endfunction

    function automatic int m_addr();
        if (m_mode == M_RUN || m_mode == M_LOAD) return m_notes;
        if (m_mode == M_DRAIN) return NN - 1;
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = M_IDLE; m_phase = 0; m_notes = 0; m_drained = 0;
            for (int r = 0; r < RW; r++) m_rows[r] = '0;
        end else begin
            case (m_mode)
                M_IDLE, M_DONE: if (start) begin
                    m_mode = M_LOAD; m_phase = 0; m_notes = 0; m_drained = 0;
                    for (int r = 0; r < RW; r++) m_rows[r] = '0;
                end
                M_LOAD: m_mode = M_RUN;
                default: if (!pause) begin
                    if (m_phase == TD - 1) begin
                        m_phase = 0;
                        for (int r = RW - 1; r > 0; r--) m_rows[r] = m_rows[r-1];
                        if (m_mode == M_RUN) begin
                            m_rows[0] = rom_tbl[m_notes];
                            m_notes++;
`ifdef BEATMAP_LOOP_EN
                            if (m_notes == NN) m_notes = 0;
`else
                            if (m_notes == NN) m_mode = M_DRAIN;
`endif
                        end else begin
                            m_rows[0] = '0;
                            m_drained++;
                            if (m_drained == RW) m_mode = M_DONE;
                        end
                    end else begin
                        m_phase++;
                    end
                end
            endcase
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        check("grid",     grid,     m_grid());
        check("hit_row",  hit_row,  m_rows[RW-1]);
        check("beat",     beat,     m_tick());
        check("note_idx", note_idx, m_notes);
        check("rom_addr", rom_addr, m_addr());
        check("busy",     busy,     (m_mode == M_LOAD || m_mode == M_RUN || m_mode == M_DRAIN));
        check("done",     done,     (m_mode == M_DONE));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Counts cycles until beat is seen, then returns just after the shift edge.
    task automatic wait_beat(output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (beat === 1'b1) seen = 1'b1;
        end
        check("beat_seen", seen, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_grid", grid, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("idle_grid", grid, 0);
        check("idle_busy", busy, 0);

        // First beat: LOAD cycle + 4 RUN cycles
        pulse_start();
        wait_beat(n);
        check("first_beat_cycles", n, 5);
        check("beat1_row0", grid[LN-1:0], 4'b1000);
        check("beat1_addr", rom_addr, 1);
        check("beat1_note_idx", note_idx, 1);

        wait_beat(n);
        check("beat_period", n, TD);

        // Pause mid-count: divider sits at 2, resumes from there
        repeat (2) @(posedge clk);
        #1 pause = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("paused_beat", beat, 1'b0);
        end
        @(posedge clk);
        #1 pause = 1'b0;
        wait_beat(n);
        check("resume_cycles", n, 2);

        wait_beat(n);
        check("beat4_hit_row", hit_row, 4'b1000);
        check("beat4_row0", grid[LN-1:0], 4'b0001);

`ifdef BEATMAP_LOOP_EN
        wait_beat(n);
        wait_beat(n);
        check("loop_wrap_note_idx", note_idx, 0);
        check("loop_wrap_addr", rom_addr, 0);
        wait_beat(n);
        check("loop_beat7_row0", grid[LN-1:0], 4'b1000);
        check("loop_beat7_note_idx", note_idx, 1);
        repeat (20) begin
            wait_beat(n);
            check("loop_done_low", done, 1'b0);
        end
        pulse_start();
        check("loop_start_ignored_busy", busy, 1'b1);
`else
        wait_beat(n);
        wait_beat(n);
        check("drain_addr", rom_addr, 5);
        check("drain_note_idx", note_idx, 6);
        check("drain_busy", busy, 1'b1);
        repeat (RW) wait_beat(n);
        check("done_grid", grid, 0);
        check("done_flag", done, 1'b1);
        check("done_busy", busy, 1'b0);

        // Restart repeats identically
        pulse_start();
        wait_beat(n);
        check("restart_first_beat_cycles", n, 5);
        check("restart_row0", grid[LN-1:0], 4'b1000);
        check("restart_note_idx", note_idx, 1);
`endif

        // Asynchronous reset mid-RUN
        wait_beat(n);
        wait_beat(n);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_grid", grid, 0);
        check("midrst_beat", beat, 1'b0);
        check("midrst_note_idx", note_idx, 0);
        check("midrst_addr", rom_addr, 0);
        check("midrst_busy", busy, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Randomized traffic against the model
        repeat (3000) begin
            @(posedge clk);
            #1;
            pause = ($urandom_range(0, 3) == 0);
            start = ($urandom_range(0, 30) == 0);
            reset = ($urandom_range(0, 700) == 0);
        end
        @(posedge clk);
        #1;
        pause = 1'b0;
        start = 1'b0;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
